// File: rtl/fpga_boot_seq.sv
// Boot sequencer: synchronises PLL lock and a bouncy fetch-enable input, holds the
// SoC in reset until lock has been stable long enough, then gates core fetch enable.
module fpga_boot_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_WAIT   = 1024,
    parameter int DEBOUNCE    = 16,
    parameter int FE_DELAY    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked_i,
    input  logic       fetch_enable_i,
    output logic       soc_rst_no,
    output logic       fetch_enable_o,
    output logic [1:0] boot_state_o,
    output logic [7:0] lock_loss_cnt_o
);

    localparam int LC_W = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    // run_cnt must be able to hold FE_DELAY itself, not just FE_DELAY-1
    localparam int RC_W = (FE_DELAY > 0) ? $clog2(FE_DELAY + 1) : 1;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'b00,
        ST_STABLE    = 2'b01,
        ST_RUN       = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] lock_sync_r;
    logic [SYNC_STAGES-1:0] fe_sync_r;
    logic                   lock_s;
    logic                   fe_s;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [LC_W-1:0]        lock_cnt_r;
    logic [LC_W-1:0]        lock_cnt_nxt_s;
    logic [7:0]             loss_cnt_r;
    logic [7:0]             loss_cnt_nxt_s;

    logic                   fe_db_r;
    logic                   fe_db_nxt_s;
    logic [DB_W-1:0]        db_cnt_r;
    logic [DB_W-1:0]        db_cnt_nxt_s;

    logic [RC_W-1:0]        run_cnt_r;
    logic [RC_W-1:0]        run_cnt_nxt_s;
    logic                   soc_rst_n_r;
    logic                   fe_out_r;
    logic                   fe_out_nxt_s;

    assign lock_s = lock_sync_r[SYNC_STAGES-1];
    assign fe_s   = fe_sync_r[SYNC_STAGES-1];

    // Synchroniser chains for the two asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_r <= '0;
            fe_sync_r   <= '0;
        end else begin
            lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], pll_locked_i};
            fe_sync_r   <= {fe_sync_r[SYNC_STAGES-2:0], fetch_enable_i};
        end
    end

    // Boot FSM next-state, lock counter and lock-loss counter
    always_comb begin
        state_nxt_s    = state_r;
        lock_cnt_nxt_s = lock_cnt_r;
        loss_cnt_nxt_s = loss_cnt_r;
        case (state_r)
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt_s    = ST_STABLE;
                    lock_cnt_nxt_s = '0;
                end else begin
                    state_nxt_s    = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_nxt_s = ST_WAIT_LOCK;
                end else if (lock_cnt_r == LC_W'(LOCK_WAIT - 1)) begin
                    // terminal count: clear rather than increment so the counter never wraps
                    state_nxt_s    = ST_RUN;
                    lock_cnt_nxt_s = '0;
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r + LC_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt_s = ST_WAIT_LOCK;
                    if (loss_cnt_r != 8'hFF) begin
                        loss_cnt_nxt_s = loss_cnt_r + 8'd1;
                    end else begin
                        loss_cnt_nxt_s = loss_cnt_r;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s    = ST_WAIT_LOCK;
                lock_cnt_nxt_s = '0;
            end
        endcase
    end

    // Fetch-enable debounce, independent of boot state
    always_comb begin
        fe_db_nxt_s  = fe_db_r;
        db_cnt_nxt_s = db_cnt_r;
        if (fe_s == fe_db_r) begin
            db_cnt_nxt_s = '0;
        end else if (db_cnt_r == DB_W'(DEBOUNCE - 1)) begin
            fe_db_nxt_s  = fe_s;
            db_cnt_nxt_s = '0;
        end else begin
            db_cnt_nxt_s = db_cnt_r + DB_W'(1);
        end
    end

    // RUN-time counter and the fetch-enable output qualifier
    always_comb begin
        run_cnt_nxt_s = '0;
        if (state_r != ST_RUN) begin
            run_cnt_nxt_s = '0;
        end else if (run_cnt_r != RC_W'(FE_DELAY)) begin
            run_cnt_nxt_s = run_cnt_r + RC_W'(1);
        end else begin
            run_cnt_nxt_s = run_cnt_r;
        end
        fe_out_nxt_s = (state_r == ST_RUN) && (run_cnt_r == RC_W'(FE_DELAY)) && fe_db_r;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_WAIT_LOCK;
            lock_cnt_r  <= '0;
            loss_cnt_r  <= 8'd0;
            fe_db_r     <= 1'b0;
            db_cnt_r    <= '0;
            run_cnt_r   <= '0;
            soc_rst_n_r <= 1'b0;
            fe_out_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            lock_cnt_r  <= lock_cnt_nxt_s;
            loss_cnt_r  <= loss_cnt_nxt_s;
            fe_db_r     <= fe_db_nxt_s;
            db_cnt_r    <= db_cnt_nxt_s;
            run_cnt_r   <= run_cnt_nxt_s;
            soc_rst_n_r <= (state_nxt_s == ST_RUN);
            fe_out_r    <= fe_out_nxt_s;
        end
    end

    assign soc_rst_no      = soc_rst_n_r;
    assign fetch_enable_o  = fe_out_r;
    assign boot_state_o    = state_r;
    assign lock_loss_cnt_o = loss_cnt_r;

endmodule
